jk_cmd_arbiter: RTL and testbench

- Shares one bank of WIDTH JK flip-flops between two command requesters, A and B.
- Accepts per-bit JK commands (hold/reset/set/toggle) through a valid/ready handshake and arbitrates round-robin.
- Drives the bank's j/k inputs for exactly one clock, then reads back the bank's q and reports done plus mismatch error.
- Sits between software-style command sources and the jk_ff bank, one jk_ff per bit.

---
 rtl/jk_cmd_arbiter.sv | 162 ++++++++++++++++
 tb/tb_jk_cmd_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_arbiter.sv
// Round-robin arbiter that sends JK commands from two requesters to a bank of WIDTH
// jk_ff cells, then reads the bank back to check the result. Optional counters: JK_CMD_STATS_EN.
module jk_cmd_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [1:0]       a_op,
  input  logic [WIDTH-1:0] a_mask,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [1:0]       b_op,
  input  logic [WIDTH-1:0] b_mask,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q,
  output logic             done,
  output logic             err,
  output logic             gnt_id
`ifdef JK_CMD_STATS_EN
  ,
  output logic [7:0]       cnt_a,
  output logic [7:0]       cnt_b,
  output logic [7:0]       cnt_err
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             done_q, done_d, err_q, err_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;   // 1 = B won most recently
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask;
  logic [WIDTH-1:0] exp_v;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mask_d   = mask_q;
    snap_d   = snap_q;
    j_d      = j_q;
    k_d      = k_q;
    done_d   = 1'b0;
    err_d    = err_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    sel_op   = a_op;
    sel_mask = a_mask;
    exp_v    = snap_q;

    case (op_q)
      2'b01:   exp_v = snap_q & ~mask_q;
      2'b10:   exp_v = snap_q | mask_q;
      2'b11:   exp_v = snap_q ^ mask_q;
      default: exp_v = snap_q;
    endcase

    case (state_q)
      IDLE: begin
        a_ready = a_valid && (!b_valid || last_q);
        b_ready = b_valid && (!a_valid || !last_q);
        if (b_ready) begin
          sel_op   = b_op;
          sel_mask = b_mask;
        end
        if (a_ready || b_ready) begin
          op_d    = sel_op;
          mask_d  = sel_mask;
          snap_d  = q;
          gnt_d   = b_ready;
          last_d  = b_ready;
          j_d     = sel_mask & {WIDTH{sel_op[1]}};
          k_d     = sel_mask & {WIDTH{sel_op[0]}};
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        j_d     = '0;
        k_d     = '0;
        state_d = CHECK;
      end
      CHECK: begin
        done_d  = 1'b1;
        err_d   = (q != exp_v);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      mask_q  <= '0;
      snap_q  <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      snap_q  <= snap_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  assign j      = j_q;
  assign k      = k_q;
  assign done   = done_q;
  assign err    = err_q;
  assign gnt_id = gnt_q;

`ifdef JK_CMD_STATS_EN
  logic [7:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, cnt_err_q, cnt_err_d;

  always_comb begin
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    cnt_err_d = cnt_err_q;
    if (a_ready && cnt_a_q != 8'hFF) cnt_a_d = cnt_a_q + 8'd1;
    if (b_ready && cnt_b_q != 8'hFF) cnt_b_d = cnt_b_q + 8'd1;
    if (state_q == CHECK && err_d && cnt_err_q != 8'hFF) cnt_err_d = cnt_err_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      cnt_err_q <= '0;
    end else begin
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      cnt_err_q <= cnt_err_d;
    end
  end

  assign cnt_a   = cnt_a_q;
  assign cnt_b   = cnt_b_q;
  assign cnt_err = cnt_err_q;
`endif

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// Self-checking bench for jk_cmd_arbiter: a behavioural JK bank, directed cases and randomized commands.
module tb_jk_cmd_arbiter;
  localparam int unsigned W = 4;

  logic         clk, rst;
  logic         a_valid, a_ready, b_valid, b_ready;
  logic [1:0]   a_op, b_op;
  logic [W-1:0] a_mask, b_mask, j, k, q;
  logic         done, err, gnt_id;
`ifdef JK_CMD_STATS_EN
  logic [7:0]   cnt_a, cnt_b, cnt_err;
`endif

  jk_cmd_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_mask(a_mask),
    .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_mask(b_mask),
    .j(j), .k(k), .q(q), .done(done), .err(err), .gnt_id(gnt_id)
`ifdef JK_CMD_STATS_EN
    , .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_err(cnt_err)
`endif
  );

  // Behavioural JK bank with a load port and a stuck-at-zero readback fault.
  logic [W-1:0] bank, load_val;
  logic         load_en, stuck;
  always @(posedge clk) begin
    if (load_en) bank <= load_val;
    else         bank <= (j & ~bank) | (~k & bank);
  end
  assign q = stuck ? '0 : bank;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;
  logic [W-1:0] mq;          // expected bank contents
  bit           last_b;      // 1 = B won most recently
  logic         prev_err;
  int unsigned  ea, eb, ee;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] apply(input logic [1:0] op, input logic [W-1:0] m,
                                         input logic [W-1:0] v);
    case (op)
      2'b01:   return v & ~m;
      2'b10:   return v | m;
      2'b11:   return v ^ m;
      default: return v;
    endcase
  endfunction

  task automatic load_bank(input logic [W-1:0] v);
    load_en = 1'b1; load_val = v;
    @(negedge clk);
    load_en = 1'b0;
    mq = v;
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge where done is high.
  task automatic cmd(input bit va, input bit vb, input logic [1:0] aop, input logic [1:0] bop,
                     input logic [W-1:0] am, input logic [W-1:0] bm, input bit keep);
    bit           wb;
    logic [1:0]   op;
    logic [W-1:0] m, dut_exp, bank_new;
    a_valid = va; b_valid = vb; a_op = aop; b_op = bop; a_mask = am; b_mask = bm;
    #1;
    wb = (va && vb) ? !last_b : vb;
    chk("a_ready", a_ready, va && !wb);
    chk("b_ready", b_ready, vb && wb);
    chk("ready_excl", a_ready & b_ready, 0);
    op = wb ? bop : aop;
    m  = wb ? bm : am;
    if (wb) eb++; else ea++;
    bank_new = apply(op, m, mq);
    dut_exp  = apply(op, m, stuck ? '0 : mq);
    @(negedge clk);
    if (!keep) begin a_valid = 1'b0; b_valid = 1'b0; end
    chk("issue_j", j, op[1] ? m : '0);
    chk("issue_k", k, op[0] ? m : '0);
    chk("issue_done", done, 0);
    chk("issue_err_hold", err, prev_err);
    chk("issue_rdy", {a_ready, b_ready}, 0);
    @(negedge clk);
    chk("check_jk", {j, k}, 0);
    chk("check_done", done, 0);
    chk("check_rdy", {a_ready, b_ready}, 0);
    @(negedge clk);
    chk("done", done, 1);
    chk("err", err, (stuck ? '0 : bank_new) != dut_exp);
    chk("gnt_id", gnt_id, wb);
    chk("q", q, stuck ? '0 : bank_new);
    if ((stuck ? '0 : bank_new) != dut_exp) ee++;
`ifdef JK_CMD_STATS_EN
    chk("cnt_a", cnt_a, (ea > 255) ? 255 : ea);
    chk("cnt_b", cnt_b, (eb > 255) ? 255 : eb);
    chk("cnt_err", cnt_err, (ee > 255) ? 255 : ee);
`endif
    prev_err = err;
    last_b   = wb;
    mq       = bank_new;
  endtask

  initial begin
    a_valid = 0; b_valid = 0; a_op = 0; b_op = 0; a_mask = 0; b_mask = 0;
    stuck = 0; load_en = 1; load_val = '0; mq = '0;
    last_b = 1; prev_err = 0; ea = 0; eb = 0; ee = 0;
    rst = 0;
    repeat (2) @(negedge clk);
    chk("rst_jk", {j, k}, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_gnt", gnt_id, 0);
    chk("rst_rdy", {a_ready, b_ready}, 0);
    load_en = 0;
    rst = 1;
    @(negedge clk);

    cmd(1, 0, 2'b10, 2'b00, 4'b0101, 4'b0000, 0);
    chk("t1_q", q, 4'b0101);
    cmd(0, 1, 2'b00, 2'b11, 4'b0000, 4'b1111, 0);
    chk("t2_q", q, 4'b1010);

    for (int n = 0; n < 4; n++)
      cmd(1, 1, 2'b11, 2'b11, 4'b0011, 4'b1100, n != 3);

    load_bank('0);
    stuck = 1;
    cmd(1, 0, 2'b10, 2'b00, 4'b0001, 4'b0000, 0);
    stuck = 0;
    load_bank(4'b0110);

    cmd(1, 0, 2'b00, 2'b00, 4'b1111, 4'b0000, 0);
    chk("hold_q", q, 4'b0110);

    // A is accepted, then reset lands mid-ISSUE: the command must vanish.
    a_valid = 1; a_op = 2'b10; a_mask = 4'b1001;
    @(negedge clk);
    a_valid = 0;
    chk("pre_rst_j", j, 4'b1001);
    #2 rst = 0;
    #1;
    chk("rst_async_jk", {j, k}, 0);
    chk("rst_async_err", err, 0);
    @(negedge clk);
    rst = 1;
    last_b = 1; prev_err = 0;
`ifdef JK_CMD_STATS_EN
    ea = 0; eb = 0; ee = 0;
`endif
    for (int n = 0; n < 4; n++) begin
      chk("no_done_after_rst", done, 0);
      @(negedge clk);
    end
    chk("rst_bank_unchanged", q, mq);
    cmd(1, 1, 2'b01, 2'b10, 4'b0100, 4'b1111, 0);

    for (int n = 0; n < 40; n++) begin
      int unsigned r;
      r = $urandom_range(0, 2);
      cmd(r != 1, r != 0, 2'($urandom), 2'($urandom), W'($urandom), W'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
